lvds_align_ctrl: RTL
====================

Name: lvds_align_ctrl

Overview:
- Word-alignment sequencer for the 7:1 LVDS receive front end. It feeds the LVDS-to-native unpacker, one 28-bit word per port.
- Walks the ports one at a time in round-robin order. For each port it issues bitslip pulses until that port's deserialized clock-lane word matches the LVDS clock pattern.
- After all ports are handled it monitors every locked port continuously and drops lock on sustained mismatch.
- Downstream logic gates use of R/G/B/HS/VS/DE on ALL_LOCKED_O.

Parameters:
- C_PORT_NUM, 4, number of LVDS ports (1..8).
- C_CLK_PATTERN, 7'b1100011, expected clock-lane word.
- C_SETTLE_CYC, 4, wait cycles after a bitslip (or port switch) before comparing (1..255).
- C_MATCH_CNT, 16, consecutive matches required to declare lock (1..255).
- C_LOSS_CNT, 8, consecutive mismatches in MONITOR that drop lock (1..255).

Ports:
- CLK_I, input, 1, pixel/word clock; all logic is on its rising edge.
- RST_I, input, 1, synchronous active-high reset.
- ALIGN_START_I, input, 1, one-cycle request to (re)start alignment.
- CLKLANE_I, input, 7*C_PORT_NUM, deserialized clock-lane words; port 0 in bits [6:0], port p in [7p+6:7p].
- BITSLIP_O, output, C_PORT_NUM, one-cycle bitslip pulse to the port's deserializer.
- LOCKED_O, output, C_PORT_NUM, per-port lock status.
- FAIL_O, output, C_PORT_NUM, per-port "no phase matched" flag.
- ALL_LOCKED_O, output, 1, every port locked and controller in MONITOR.
- BUSY_O, output, 1, alignment sequence in progress.

Behaviour:
- Clocking and reset: one clock (CLK_I); reset RST_I is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; port index, slip count, settle count, match count and all loss counters 0.
- All outputs are registered.
- States: IDLE, SETTLE, CHECK, SLIP, NEXT, MONITOR.
- IDLE:
  - BUSY_O=0.
  - ALIGN_START_I=1 → clear LOCKED_O and FAIL_O, idx=0, slip=0, go to SETTLE.
  - BUSY_O=1 from the next cycle.
- SETTLE: count C_SETTLE_CYC cycles, then go to CHECK with match count=0.
- CHECK, one comparison per cycle of CLKLANE_I[idx] against C_CLK_PATTERN:
  - Match: increment match count. On reaching C_MATCH_CNT, set LOCKED_O[idx] and go to NEXT.
  - Mismatch with slip<6: go to SLIP. Any mismatch resets the match count.
  - Mismatch with slip==6 (all 7 phases tried): set FAIL_O[idx] and go to NEXT.
- SLIP: BITSLIP_O[idx]=1 for exactly one cycle; slip++; go to SETTLE. At most one BITSLIP_O bit is high at any time.
- NEXT:
  - idx==C_PORT_NUM-1 → go to MONITOR.
  - Otherwise idx++, slip=0, go to SETTLE.
- MONITOR:
  - BUSY_O=0.
  - Every port with LOCKED_O=1 is checked each cycle, in parallel.
  - A mismatch increments that port's loss counter; a match clears it.
  - Counter reaching C_LOSS_CNT → clear LOCKED_O[p] on that edge and clear the counter.
  - Lost ports are not re-aligned automatically.
  - ALIGN_START_I=1 → same action as in IDLE.
- ALL_LOCKED_O:
  - Registered: 1 when state==MONITOR and &LOCKED_O.
  - Rises one cycle after MONITOR is entered; falls one cycle after any LOCKED_O bit clears.
- ALIGN_START_I is ignored while BUSY_O=1.
- Simultaneous events:
  - ALIGN_START_I in the same cycle as a loss event: restart wins and all flags clear.
  - RST_I during any state: next edge returns to reset values, and any in-flight BITSLIP_O pulse ends.
- Counter widths are 8 bits and saturate where relevant.
- C_PORT_NUM=1 is legal: NEXT goes straight to MONITOR.

Test Plan (C_PORT_NUM=4, C_SETTLE_CYC=4, C_MATCH_CNT=16, C_LOSS_CNT=8):
1. All lanes = 7'b1100011, pulse ALIGN_START_I → no BITSLIP_O pulse; LOCKED_O=4'hF; FAIL_O=0; ALL_LOCKED_O=1 within 90 cycles; BUSY_O falls the cycle MONITOR is entered.
2. Port 2 rotated right by 3; the bench model applies one rotation per BITSLIP_O[2] pulse → exactly 3 pulses on bit 2 only, spaced ≥5 cycles apart; LOCKED_O=4'hF.
3. Port 1 stuck at 7'h00 → exactly 6 pulses on BITSLIP_O[1]; FAIL_O=4'b0010; LOCKED_O=4'b1101; ALL_LOCKED_O=0; controller ends in MONITOR.
4. In MONITOR, corrupt port 3 for 7 cycles → LOCKED_O unchanged. Then 8 cycles → LOCKED_O[3]=0 and ALL_LOCKED_O=0 one cycle later; the re-asserted pattern does not restore lock.
5. Port 0 matches 10 cycles, mismatches once, then is correct → one BITSLIP_O[0] pulse, match count restarts from 0, and lock is reached after 16 further matches.
6. Assert RST_I one cycle during SLIP → BITSLIP_O=0, BUSY_O=0, LOCKED_O=0 after that edge. ALIGN_START_I pulsed while BUSY_O=1 → no restart, and idx progression is unchanged.

Source files
------------

// File: rtl/lvds_align_if.sv
// Bundle of the alignment controller's request, clock-lane and status signals.
// master: the LVDS front end / system side; slave: the alignment controller.
interface lvds_align_if #(
  parameter int unsigned C_PORT_NUM = 4
);
  logic                      ALIGN_START_I;
  logic [7*C_PORT_NUM-1:0]   CLKLANE_I;
  logic [C_PORT_NUM-1:0]     BITSLIP_O;
  logic [C_PORT_NUM-1:0]     LOCKED_O;
  logic [C_PORT_NUM-1:0]     FAIL_O;
  logic                      ALL_LOCKED_O;
  logic                      BUSY_O;

  modport master (
    output ALIGN_START_I,
    output CLKLANE_I,
    input  BITSLIP_O,
    input  LOCKED_O,
    input  FAIL_O,
    input  ALL_LOCKED_O,
    input  BUSY_O
  );

  modport slave (
    input  ALIGN_START_I,
    input  CLKLANE_I,
    output BITSLIP_O,
    output LOCKED_O,
    output FAIL_O,
    output ALL_LOCKED_O,
    output BUSY_O
  );
endinterface

// File: rtl/lvds_align_ctrl.sv
// Word-alignment sequencer for the 7:1 LVDS receive front end.
// Ports are aligned one at a time: bitslip until the clock-lane word matches
// the LVDS clock pattern for C_MATCH_CNT consecutive cycles, or flag the port
// as failed after all 7 phases. Afterwards every locked port is monitored and
// drops lock after C_LOSS_CNT consecutive mismatches.
module lvds_align_ctrl #(
  parameter int unsigned C_PORT_NUM    = 4,
  parameter logic [6:0]  C_CLK_PATTERN = 7'b1100011,
  parameter int unsigned C_SETTLE_CYC  = 4,
  parameter int unsigned C_MATCH_CNT   = 16,
  parameter int unsigned C_LOSS_CNT    = 8
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  lvds_align_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_SLIP    = 3'd3;
  localparam logic [2:0] S_NEXT    = 3'd4;
  localparam logic [2:0] S_MONITOR = 3'd5;

  // Terminal counts: counters compare against N-1 so the Nth event fires.
  localparam logic [7:0] SETTLE_LAST = 8'(C_SETTLE_CYC - 1);
  localparam logic [7:0] MATCH_LAST  = 8'(C_MATCH_CNT - 1);
  localparam logic [7:0] LOSS_LAST   = 8'(C_LOSS_CNT - 1);
  localparam logic [7:0] LAST_PORT   = 8'(C_PORT_NUM - 1);
  // Slip count 6 means all seven phases of the 7-bit word have been tried.
  localparam logic [7:0] LAST_SLIP   = 8'd6;

  logic [2:0]            state;
  logic [7:0]            idx;
  logic [7:0]            slip_cnt;
  logic [7:0]            settle_cnt;
  logic [7:0]            match_cnt;
  logic [7:0]            loss_cnt [C_PORT_NUM];

  logic [C_PORT_NUM-1:0] bitslip_q;
  logic [C_PORT_NUM-1:0] locked_q;
  logic [C_PORT_NUM-1:0] fail_q;
  logic                  all_locked_q;
  logic                  busy_q;

  logic [C_PORT_NUM-1:0] port_match;
  logic [C_PORT_NUM-1:0] idx_oh;
  logic                  cur_match;
  logic                  start_ok;

  // Per-port pattern compare, one-hot of the port under alignment and its match.
  always_comb begin
    port_match = '0;
    idx_oh     = '0;
    cur_match  = 1'b0;
    for (int p = 0; p < C_PORT_NUM; p++) begin
      port_match[p] = (bus.CLKLANE_I[7*p +: 7] == C_CLK_PATTERN);
      if (idx == 8'(p)) begin
        idx_oh[p] = 1'b1;
        cur_match = port_match[p];
      end
    end
  end

  // A restart is honoured only while no alignment sequence is running.
  assign start_ok = bus.ALIGN_START_I && ((state == S_IDLE) || (state == S_MONITOR));

  // Alignment sequencer, lock monitor and registered status outputs.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state        <= S_IDLE;
      idx          <= '0;
      slip_cnt     <= '0;
      settle_cnt   <= '0;
      match_cnt    <= '0;
      for (int p = 0; p < C_PORT_NUM; p++) loss_cnt[p] <= '0;
      bitslip_q    <= '0;
      locked_q     <= '0;
      fail_q       <= '0;
      all_locked_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      bitslip_q    <= '0;
      all_locked_q <= (state == S_MONITOR) && (&locked_q);
      if (start_ok) begin
        // Restart takes priority over any loss event in the same cycle.
        locked_q     <= '0;
        fail_q       <= '0;
        idx          <= '0;
        slip_cnt     <= '0;
        settle_cnt   <= '0;
        match_cnt    <= '0;
        for (int p = 0; p < C_PORT_NUM; p++) loss_cnt[p] <= '0;
        all_locked_q <= 1'b0;
        busy_q       <= 1'b1;
        state        <= S_SETTLE;
      end else begin
        case (state)
          S_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              settle_cnt <= '0;
              match_cnt  <= '0;
              state      <= S_CHECK;
            end else begin
              settle_cnt <= settle_cnt + 8'd1;
            end
          end
          S_CHECK: begin
            if (cur_match) begin
              if (match_cnt == MATCH_LAST) begin
                locked_q <= locked_q | idx_oh;
                state    <= S_NEXT;
              end else begin
                match_cnt <= match_cnt + 8'd1;
              end
            end else begin
              match_cnt <= '0;
              if (slip_cnt < LAST_SLIP) begin
                // Pulse is visible for exactly the single SLIP cycle.
                bitslip_q <= idx_oh;
                state     <= S_SLIP;
              end else begin
                fail_q <= fail_q | idx_oh;
                state  <= S_NEXT;
              end
            end
          end
          S_SLIP: begin
            slip_cnt <= slip_cnt + 8'd1;
            state    <= S_SETTLE;
          end
          S_NEXT: begin
            if (idx == LAST_PORT) begin
              busy_q <= 1'b0;
              state  <= S_MONITOR;
            end else begin
              idx      <= idx + 8'd1;
              slip_cnt <= '0;
              state    <= S_SETTLE;
            end
          end
          S_MONITOR: begin
            // Locked ports are watched in parallel; unlocked ones are left alone.
            for (int p = 0; p < C_PORT_NUM; p++) begin
              if (locked_q[p] && !port_match[p]) begin
                if (loss_cnt[p] == LOSS_LAST) begin
                  locked_q[p] <= 1'b0;
                  loss_cnt[p] <= '0;
                end else begin
                  loss_cnt[p] <= loss_cnt[p] + 8'd1;
                end
              end else begin
                loss_cnt[p] <= '0;
              end
            end
          end
          S_IDLE: begin
            busy_q <= 1'b0;
          end
          default: begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.BITSLIP_O    = bitslip_q;
  assign bus.LOCKED_O     = locked_q;
  assign bus.FAIL_O       = fail_q;
  assign bus.ALL_LOCKED_O = all_locked_q;
  assign bus.BUSY_O       = busy_q;

endmodule
